reservation_station: RTL and testbench

Parametrised out-of-order issue queue between the decoder/dispatch stage and the ALU. It holds renamed ALU instructions until both source operands are present. Operands are captured from any of `NCDB` result broadcast buses. Each cycle it issues the oldest ready entry (age-ordered, not slot-ordered) to the ALU through a registered issue port. It replaces the fixed 15-entry, 3-bus, lowest-slot-first station: all `DEPTH` slots are usable, bus count is generic, and fill level is reported.

---
 rtl/reservation_station.sv | 194 +++++++++++++++++++
 tb/tb_reservation_station.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - age-ordered ALU reservation station with multi-bus operand wakeup
module reservation_station #(
    parameter int DEPTH = 16,
    parameter int ROB_W = 4,
    parameter int XLEN  = 32,
    parameter int OP_W  = 6,
    parameter int NCDB  = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       in_flush,
    input  logic                       in_dispatch_valid,
    input  logic [ROB_W-1:0]           in_dispatch_rob,
    input  logic [OP_W-1:0]            in_dispatch_op,
    input  logic [XLEN-1:0]            in_dispatch_value1,
    input  logic [XLEN-1:0]            in_dispatch_value2,
    input  logic [XLEN-1:0]            in_dispatch_imm,
    input  logic [XLEN-1:0]            in_dispatch_pc,
    input  logic [ROB_W-1:0]           in_dispatch_tag1,
    input  logic [ROB_W-1:0]           in_dispatch_tag2,
    input  logic [NCDB-1:0]            in_cdb_valid,
    input  logic [NCDB*ROB_W-1:0]      in_cdb_tag,
    input  logic [NCDB*XLEN-1:0]       in_cdb_value,
    output logic                       out_full,
    output logic [$clog2(DEPTH+1)-1:0] out_count,
    output logic                       out_issue_valid,
    output logic [OP_W-1:0]            out_issue_op,
    output logic [XLEN-1:0]            out_issue_value1,
    output logic [XLEN-1:0]            out_issue_value2,
    output logic [XLEN-1:0]            out_issue_imm,
    output logic [XLEN-1:0]            out_issue_pc,
    output logic [ROB_W-1:0]           out_issue_rob
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [ROB_W-1:0] rob_q [DEPTH];
    logic [ROB_W-1:0] q1    [DEPTH];
    logic [ROB_W-1:0] q2    [DEPTH];
    logic [XLEN-1:0]  v1    [DEPTH];
    logic [XLEN-1:0]  v2    [DEPTH];
    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [XLEN-1:0]  pc_q  [DEPTH];
    logic [DEPTH-1:0] older [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] pick;
    logic [IW-1:0]    sel_idx;
    logic [IW-1:0]    alloc_idx;
    logic             have_sel;
    logic             have_free;
    logic             alloc;
    logic [CW-1:0]    count;
    logic [ROB_W-1:0] nq1 [DEPTH];
    logic [ROB_W-1:0] nq2 [DEPTH];
    logic [XLEN-1:0]  nv1 [DEPTH];
    logic [XLEN-1:0]  nv2 [DEPTH];
    logic [ROB_W-1:0] dq1, dq2;
    logic [XLEN-1:0]  dv1, dv2;

    // Descending scan so the lowest free index is the one left in alloc_idx.
    always_comb begin
        count     = '0;
        ready     = '0;
        have_free = 1'b0;
        alloc_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            count    = count + CW'(valid[i]);
            ready[i] = valid[i] && (q1[i] == '0) && (q2[i] == '0);
            if (!valid[i]) begin
                have_free = 1'b1;
                alloc_idx = IW'(i);
            end
        end
    end

    always_comb begin
        pick     = '0;
        have_sel = 1'b0;
        sel_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pick[i] = ready[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && older[j][i]) pick[i] = 1'b0;
            end
            if (pick[i]) begin
                have_sel = 1'b1;
                sel_idx  = IW'(i);
            end
        end
    end

    // Buses scanned high to low so the lowest matching bus overrides.
    always_comb begin
        dq1 = in_dispatch_tag1;
        dq2 = in_dispatch_tag2;
        dv1 = in_dispatch_value1;
        dv2 = in_dispatch_value2;
        for (int i = 0; i < DEPTH; i++) begin
            nq1[i] = q1[i];
            nq2[i] = q2[i];
            nv1[i] = v1[i];
            nv2[i] = v2[i];
        end
        for (int k = NCDB - 1; k >= 0; k--) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (in_cdb_valid[k] && q1[i] != '0 && in_cdb_tag[k*ROB_W +: ROB_W] == q1[i]) begin
                    nq1[i] = '0;
                    nv1[i] = in_cdb_value[k*XLEN +: XLEN];
                end
                if (in_cdb_valid[k] && q2[i] != '0 && in_cdb_tag[k*ROB_W +: ROB_W] == q2[i]) begin
                    nq2[i] = '0;
                    nv2[i] = in_cdb_value[k*XLEN +: XLEN];
                end
            end
            if (in_cdb_valid[k] && in_dispatch_tag1 != '0 && in_cdb_tag[k*ROB_W +: ROB_W] == in_dispatch_tag1) begin
                dq1 = '0;
                dv1 = in_cdb_value[k*XLEN +: XLEN];
            end
            if (in_cdb_valid[k] && in_dispatch_tag2 != '0 && in_cdb_tag[k*ROB_W +: ROB_W] == in_dispatch_tag2) begin
                dq2 = '0;
                dv2 = in_cdb_value[k*XLEN +: XLEN];
            end
        end
    end

    assign alloc     = in_dispatch_valid && have_free;
    assign out_full  = !have_free;
    assign out_count = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid            <= '0;
            out_issue_valid  <= 1'b0;
            out_issue_op     <= '0;
            out_issue_value1 <= '0;
            out_issue_value2 <= '0;
            out_issue_imm    <= '0;
            out_issue_pc     <= '0;
            out_issue_rob    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                older[i] <= '0;
                op_q[i]  <= '0;
                rob_q[i] <= '0;
                q1[i]    <= '0;
                q2[i]    <= '0;
                v1[i]    <= '0;
                v2[i]    <= '0;
                imm_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else if (rdy) begin
            if (in_flush) begin
                valid           <= '0;
                out_issue_valid <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid[i]) begin
                        q1[i] <= nq1[i];
                        q2[i] <= nq2[i];
                        v1[i] <= nv1[i];
                        v2[i] <= nv2[i];
                    end
                end
                out_issue_valid <= have_sel;
                if (have_sel) begin
                    out_issue_op     <= op_q[sel_idx];
                    out_issue_value1 <= v1[sel_idx];
                    out_issue_value2 <= v2[sel_idx];
                    out_issue_imm    <= imm_q[sel_idx];
                    out_issue_pc     <= pc_q[sel_idx];
                    out_issue_rob    <= rob_q[sel_idx];
                    valid[sel_idx]   <= 1'b0;
                end
                if (alloc) begin
                    for (int j = 0; j < DEPTH; j++) older[j][alloc_idx] <= valid[j];
                    older[alloc_idx] <= '0;
                    valid[alloc_idx] <= 1'b1;
                    op_q[alloc_idx]  <= in_dispatch_op;
                    rob_q[alloc_idx] <= in_dispatch_rob;
                    imm_q[alloc_idx] <= in_dispatch_imm;
                    pc_q[alloc_idx]  <= in_dispatch_pc;
                    q1[alloc_idx]    <= dq1;
                    q2[alloc_idx]    <= dq2;
                    v1[alloc_idx]    <= dv1;
                    v2[alloc_idx]    <= dv2;
                end
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - reservation_station bench against an in-order queue reference model
module tb_reservation_station;
    localparam int DEPTH = 16, ROB_W = 4, XLEN = 32, OP_W = 6, NCDB = 3;
    localparam int CW = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst, rdy, flush, dv;
    logic [ROB_W-1:0] d_rob, d_t1, d_t2;
    logic [OP_W-1:0]  d_op;
    logic [XLEN-1:0]  d_v1, d_v2, d_imm, d_pc;
    logic [NCDB-1:0]       cdb_valid;
    logic [NCDB*ROB_W-1:0] cdb_tag;
    logic [NCDB*XLEN-1:0]  cdb_value;
    logic             out_full, out_issue_valid;
    logic [CW-1:0]    out_count;
    logic [OP_W-1:0]  out_issue_op;
    logic [XLEN-1:0]  out_issue_value1, out_issue_value2, out_issue_imm, out_issue_pc;
    logic [ROB_W-1:0] out_issue_rob;

    reservation_station #(.DEPTH(DEPTH), .ROB_W(ROB_W), .XLEN(XLEN), .OP_W(OP_W), .NCDB(NCDB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_flush(flush),
        .in_dispatch_valid(dv), .in_dispatch_rob(d_rob), .in_dispatch_op(d_op),
        .in_dispatch_value1(d_v1), .in_dispatch_value2(d_v2),
        .in_dispatch_imm(d_imm), .in_dispatch_pc(d_pc),
        .in_dispatch_tag1(d_t1), .in_dispatch_tag2(d_t2),
        .in_cdb_valid(cdb_valid), .in_cdb_tag(cdb_tag), .in_cdb_value(cdb_value),
        .out_full(out_full), .out_count(out_count), .out_issue_valid(out_issue_valid),
        .out_issue_op(out_issue_op), .out_issue_value1(out_issue_value1),
        .out_issue_value2(out_issue_value2), .out_issue_imm(out_issue_imm),
        .out_issue_pc(out_issue_pc), .out_issue_rob(out_issue_rob)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROB_W-1:0] rob, q1, q2;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  v1, v2, imm, pc;
    } ent_t;

    ent_t mq[$];
    logic             m_iv;
    logic [OP_W-1:0]  m_op;
    logic [ROB_W-1:0] m_rob;
    logic [XLEN-1:0]  m_v1, m_v2, m_imm, m_pc;
    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic int bus_hit(input logic [ROB_W-1:0] t);
        if (t == '0) return -1;
        for (int k = 0; k < NCDB; k++)
            if (cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == t) return k;
        return -1;
    endfunction

    function automatic ent_t wake(input ent_t e);
        ent_t r = e;
        int h1 = bus_hit(e.q1);
        int h2 = bus_hit(e.q2);
        if (h1 >= 0) begin r.q1 = '0; r.v1 = cdb_value[h1*XLEN +: XLEN]; end
        if (h2 >= 0) begin r.q2 = '0; r.v2 = cdb_value[h2*XLEN +: XLEN]; end
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_iv = 0; m_op = '0; m_rob = '0; m_v1 = '0; m_v2 = '0; m_imm = '0; m_pc = '0;
    endtask

    // Queue order is dispatch order, so the first ready element is the oldest ready one.
    task automatic model_step();
        int pre, found;
        ent_t e;
        if (!rdy) return;
        if (flush) begin
            mq.delete();
            m_iv = 0;
            return;
        end
        pre = mq.size();
        found = -1;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].q1 == '0 && mq[i].q2 == '0) begin found = i; break; end
        if (found >= 0) begin
            m_iv = 1; m_op = mq[found].op; m_rob = mq[found].rob;
            m_v1 = mq[found].v1; m_v2 = mq[found].v2; m_imm = mq[found].imm; m_pc = mq[found].pc;
            mq.delete(found);
        end else m_iv = 0;
        for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
        if (dv && pre < DEPTH) begin
            e.rob = d_rob; e.op = d_op; e.q1 = d_t1; e.q2 = d_t2;
            e.v1 = d_v1; e.v2 = d_v2; e.imm = d_imm; e.pc = d_pc;
            mq.push_back(wake(e));
        end
    endtask

    task automatic compare_all();
        check("issue_valid", 64'(out_issue_valid), 64'(m_iv));
        check("count", 64'(out_count), 64'(mq.size()));
        check("full", 64'(out_full), 64'(mq.size() == DEPTH));
        check("issue_rob", 64'(out_issue_rob), 64'(m_rob));
        check("issue_op", 64'(out_issue_op), 64'(m_op));
        check("issue_v1", 64'(out_issue_value1), 64'(m_v1));
        check("issue_v2", 64'(out_issue_value2), 64'(m_v2));
        check("issue_imm", 64'(out_issue_imm), 64'(m_imm));
        check("issue_pc", 64'(out_issue_pc), 64'(m_pc));
    endtask

    task automatic idle_inputs();
        dv = 0; flush = 0; cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
        d_rob = '0; d_op = '0; d_t1 = '0; d_t2 = '0; d_v1 = '0; d_v2 = '0; d_imm = '0; d_pc = '0;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        idle_inputs();
    endtask

    task automatic dispatch(input logic [ROB_W-1:0] rob, input logic [ROB_W-1:0] t1,
                            input logic [ROB_W-1:0] t2, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b);
        dv = 1; d_rob = rob; d_op = OP_W'(rob + 1); d_t1 = t1; d_t2 = t2;
        d_v1 = a; d_v2 = b; d_imm = 32'h1000 + 32'(rob); d_pc = 32'h8000 + 32'(rob) * 4;
    endtask

    task automatic bcast(input int k, input logic [ROB_W-1:0] t, input logic [XLEN-1:0] v);
        cdb_valid[k] = 1'b1;
        cdb_tag[k*ROB_W +: ROB_W] = t;
        cdb_value[k*XLEN +: XLEN] = v;
    endtask

    initial begin
        rst = 1; rdy = 1;
        idle_inputs();
        model_reset();
        #2;
        compare_all();
        #10 rst = 0;

        dispatch(3, 0, 0, 5, 7); cycle();
        cycle();
        check("ready_issue_rob", 64'(out_issue_rob), 64'd3);
        check("ready_issue_v2", 64'(out_issue_value2), 64'd7);
        cycle();

        dispatch(1, 9, 0, 0, 11); cycle();
        dispatch(2, 0, 0, 21, 22); cycle();
        dispatch(4, 0, 9, 41, 0); cycle();
        cycle();
        bcast(2, 9, 32'h55); cycle();
        cycle();
        check("age_first_rob", 64'(out_issue_rob), 64'd1);
        cycle();
        check("age_second_v2", 64'(out_issue_value2), 64'h55);
        cycle();

        dispatch(7, 6, 0, 0, 3); bcast(0, 6, 32'hDEAD); cycle();
        cycle();
        check("same_cycle_v1", 64'(out_issue_value1), 64'hDEAD);
        dispatch(8, 0, 5, 1, 0); bcast(1, 5, 32'h11); bcast(2, 5, 32'h22); cycle();
        cycle();
        check("low_bus_wins", 64'(out_issue_value2), 64'h11);

        for (int i = 0; i < DEPTH; i++) begin
            dispatch(ROB_W'(i % 15 + 1), 15, 0, 0, 32'(i)); cycle();
        end
        check("full_flag", 64'(out_full), 64'd1);
        dispatch(13, 0, 0, 9, 9); cycle();
        bcast(1, 15, 32'hF00D); cycle();
        for (int i = 0; i < DEPTH + 2; i++) cycle();

        for (int i = 0; i < 5; i++) begin
            dispatch(ROB_W'(i + 1), 14, 0, 0, 0); cycle();
        end
        flush = 1; dispatch(9, 0, 0, 1, 2); cycle();
        dispatch(10, 0, 0, 3, 4); cycle();
        cycle();

        dispatch(11, 0, 0, 6, 6); cycle();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            bcast(0, 3, 32'h33); cycle();
        end
        rdy = 1;
        cycle();

        for (int n = 0; n < 400; n++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) != 0) begin
                dv = 1; d_rob = ROB_W'($urandom_range(1, 15)); d_op = OP_W'($urandom);
                d_t1 = ($urandom_range(0, 1) != 0) ? '0 : ROB_W'($urandom_range(1, 7));
                d_t2 = ($urandom_range(0, 1) != 0) ? '0 : ROB_W'($urandom_range(1, 7));
                d_v1 = $urandom; d_v2 = $urandom; d_imm = $urandom; d_pc = $urandom;
            end
            for (int k = 0; k < NCDB; k++)
                if ($urandom_range(0, 9) < 4) bcast(k, ROB_W'($urandom_range(1, 7)), $urandom);
            cycle();
            rdy = 1;
        end

        dispatch(12, 0, 0, 1, 1); cycle();
        rst = 1;
        #2;
        model_reset();
        compare_all();
        rst = 0;
        cycle();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
